reg_bank_wb: RTL and testbench
==============================

Name: reg_bank_wb

Overview:
- Register bank at the receiving end of the writeback path: takes the data word chosen by the writeback-source mux and commits it to the architectural register file.
- Provides the two operand read ports to the datapath (rs/rt for the A/B registers).
- Adds a sequential bulk-clear engine that restores the reset image without asserting reset, with a write-ready handshake toward the control unit.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- SP_INDEX, 29, index of the stack pointer register.
- SP_RESET, 227, value loaded into SP_INDEX on reset or clear.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_addr  in  ADDR_W  read port A index.
- rt_addr  in  ADDR_W  read port B index.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- reg_write  in  1  write request (from control).
- wr_addr  in  ADDR_W  write index (from the RegDst mux).
- wr_data  in  DATA_W  write data (from the writeback-source mux).
- wr_ready  out  1  high when a write is accepted this cycle.
- clear_req  in  1  single-cycle request to start a bulk clear.
- busy  out  1  high while the clear engine runs.

Behaviour:
- Interface (decided): one clock, clk. Reset is asynchronous and active-low on port reset. All state resets immediately on reset low, independent of clk.
- Reset image:
  - all registers = 0, except reg[SP_INDEX] = SP_RESET;
  - FSM = IDLE, busy = 0, wr_ready = 1, clear index = 1.
- Reads:
  - combinational, zero latency.
  - rs_data = reg[rs_addr], rt_data = reg[rt_addr].
  - index 0 always reads 0.
- Writes:
  - committed on the rising edge when reg_write && wr_ready.
  - a write to index 0 is discarded.
  - a write becomes visible on the read ports the cycle after the edge (no bypass unless the optional feature is enabled).
- wr_ready = (state == IDLE).
  - when wr_ready = 0, reg_write is ignored and the write is not queued.
  - control must hold reg_write until it sees wr_ready = 1.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req = 1; idx loads 1.
  - In CLEAR, each cycle writes reg[idx] = (idx == SP_INDEX) ? SP_RESET : 0, then idx increments.
  - CLEAR -> IDLE after the write of idx = 2**ADDR_W - 1, so the clear takes 31 cycles at the defaults.
  - busy = (state == CLEAR).
- Same-edge events in IDLE:
  - clear_req and reg_write both high: the write commits on that edge and CLEAR starts on the next cycle, so the written register is later cleared.
- clear_req while in CLEAR: ignored; it does not restart or extend the clear.
- Reads during CLEAR return the current contents: already-cleared registers show reset values, the rest show their old values.
- reset low mid-clear: reset image applied at once, FSM returns to IDLE.
- Widths: no arithmetic on data. idx is ADDR_W bits and its wrap from all-ones is never used, because the exit happens at all-ones.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined:
  - if reg_write && wr_ready && wr_addr != 0 && wr_addr == rs_addr, then rs_data = wr_data in the same cycle;
  - same rule for rt.
  - no bypass from the clear engine.
- Undefined: read ports show only stored contents, i.e. the new value appears one cycle after the write.

Decomposition:
- Shared package reg_bank_pkg holds:
  - constants DATA_W, ADDR_W, SP_INDEX, SP_RESET, ZERO_REG = 0;
  - enum clear_state_t {IDLE, CLEAR}.
- One natural sub-module: reg_bank_clear_fsm (state, idx, busy, wr_ready, internal clear-write strobe/index).
- The storage array and read muxing stay in the top level.

Test Plan:
- Reset: pulse reset low asynchronously (not on a clk edge). Then reg 0..31 all read 0, except reg 29 = 227, and wr_ready = 1, busy = 0.
- Write/read: write 0xDEADBEEF to reg 8. Same cycle, rs_addr = 8 reads old 0 (bypass off) or 0xDEADBEEF (bypass on). Next cycle reads 0xDEADBEEF. A write of 0x1234 to reg 0 still reads 0.
- Clear: fill reg 1..31 with index*3, pulse clear_req.
  - busy is high exactly 31 cycles and wr_ready is low throughout.
  - mid-clear, reg 10 = 0 after its slot and reg 20 = 60 before its slot.
  - at the end, all registers = 0 and reg 29 = 227.
- Same-edge: in IDLE, reg_write to reg 31 = 0xFFFF with clear_req high. The write commits (reads 0xFFFF one cycle), then reg 31 = 0 after the clear.
- Blocked write: during CLEAR, hold reg_write to reg 5 = 0xAA. Nothing commits until wr_ready returns; it commits on the first IDLE edge, after which reg 5 = 0xAA.
- Reset mid-clear: assert reset at clear cycle 12. Immediately state = IDLE and busy = 0, and all registers hold the reset image.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the writeback register bank and its
// bulk-clear engine.
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int SP_INDEX = 29;
    localparam int SP_RESET = 227;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_clear_fsm.sv
// Sequential bulk-clear engine: walks indices 1..2**ADDR_W-1 one per cycle,
// emitting the reset image for each, and gates external writes while running.
module reg_bank_clear_fsm #(
    parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
    parameter int SP_INDEX = reg_bank_pkg::SP_INDEX,
    parameter int SP_RESET = reg_bank_pkg::SP_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              wr_ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic [DATA_W-1:0] clr_data
);
    import reg_bank_pkg::*;

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDX_SP    = ADDR_W'(SP_INDEX);

    clear_state_t      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Requests arriving while a clear is running are deliberately dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = IDX_FIRST;
                end
            end
            CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = IDX_FIRST;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        wr_ready = (state_q == IDLE);
        clr_we   = (state_q == CLEAR);
        clr_idx  = idx_q;
        clr_data = (idx_q == IDX_SP) ? DATA_W'(SP_RESET) : {DATA_W{1'b0}};
    end

endmodule : reg_bank_clear_fsm

// File: rtl/reg_bank_wb.sv
// Architectural register file at the end of the writeback path, with two
// combinational read ports and a bulk-clear engine. Define REG_BANK_BYPASS_EN
// to forward an accepted write to matching read ports in the same cycle.
module reg_bank_wb #(
    parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
    parameter int SP_INDEX = reg_bank_pkg::SP_INDEX,
    parameter int SP_RESET = reg_bank_pkg::SP_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear_req,
    output logic              busy
);
    import reg_bank_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] clr_data;
    logic              wr_fire;
    logic [DATA_W-1:0] rd_vec [NREG];

    reg_bank_clear_fsm #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SP_INDEX (SP_INDEX),
        .SP_RESET (SP_RESET)
    ) u_clear_fsm (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_ready  (wr_ready),
        .clr_we    (clr_we),
        .clr_idx   (clr_idx),
        .clr_data  (clr_data)
    );

    assign wr_fire = reg_write && wr_ready && (wr_addr != ADDR_W'(ZERO_REG));

    // Register 0 has no storage; its read slot is hard-wired to zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign rd_vec[gi] = {DATA_W{1'b0}};
            end else begin : g_store
                localparam logic [DATA_W-1:0] RST_VAL =
                    (gi == SP_INDEX) ? DATA_W'(SP_RESET) : {DATA_W{1'b0}};

                logic [DATA_W-1:0] reg_q, reg_d;

                always_comb begin
                    reg_d = reg_q;
                    if (clr_we && (clr_idx == ADDR_W'(gi))) begin
                        reg_d = clr_data;
                    end else if (wr_fire && (wr_addr == ADDR_W'(gi))) begin
                        reg_d = wr_data;
                    end
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        reg_q <= RST_VAL;
                    end else begin
                        reg_q <= reg_d;
                    end
                end

                assign rd_vec[gi] = reg_q;
            end
        end
    endgenerate

`ifdef REG_BANK_BYPASS_EN
    assign rs_data = (wr_fire && (wr_addr == rs_addr)) ? wr_data : rd_vec[rs_addr];
    assign rt_data = (wr_fire && (wr_addr == rt_addr)) ? wr_data : rd_vec[rt_addr];
`else
    assign rs_data = rd_vec[rs_addr];
    assign rt_data = rd_vec[rt_addr];
`endif

endmodule : reg_bank_wb

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: a register-array model with a clear
// countdown is compared every cycle, plus hand-computed spot values.
module tb_reg_bank_wb;

    localparam int NREG = 32;
    localparam int SPI  = 29;
    localparam int SPR  = 227;
`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        reg_write, wr_ready, clear_req, busy;

    always #5 clk = ~clk;

    reg_bank_wb dut (
        .clk       (clk),
        .reset     (rst_n),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .reg_write (reg_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clear_req (clear_req),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain array plus "cycles of clear remaining"; the register being
    // cleared is NREG - remaining.
    logic [31:0] mdl_mem [NREG];
    int          clr_left;

    function automatic logic [31:0] image(input int i);
        return (i == SPI) ? 32'(SPR) : 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mdl_mem[i] <= image(i);
            clr_left <= 0;
        end else if (clr_left != 0) begin
            mdl_mem[NREG - clr_left] <= image(NREG - clr_left);
            clr_left <= clr_left - 1;
        end else begin
            if (reg_write && wr_addr != 5'd0) mdl_mem[wr_addr] <= wr_data;
            if (clear_req) clr_left <= NREG - 1;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : mdl_mem[a];
        if (BYP && clr_left == 0 && reg_write && wr_addr != 5'd0 && wr_addr == a) v = wr_data;
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rs_data", rs_data, model_read(rs_addr));
            chk("rt_data", rt_data, model_read(rt_addr));
            chk("wr_ready", 32'(wr_ready), 32'(clr_left == 0));
            chk("busy", 32'(busy), 32'(clr_left != 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep();
        for (int i = 0; i < NREG; i++) begin
            step();
            reg_write = 1'b0;
            clear_req = 1'b0;
            rs_addr   = 5'(i);
            rt_addr   = 5'(NREG - 1 - i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int ready_n;
        reg_write = 1'b0; clear_req = 1'b0;
        wr_addr = 5'd0; wr_data = 32'd0;
        rs_addr = 5'd29; rt_addr = 5'd0;

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sp", rs_data, 32'd227);
        chk("rst_r0", rt_data, 32'd0);
        #20 rst_n = 1'b1;
        sweep();

        // Write/read and zero register
        step(); reg_write = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; rs_addr = 5'd8; rt_addr = 5'd8;
        #2 chk("wr8_same_cycle", rs_data, BYP ? 32'hDEADBEEF : 32'd0);
        step(); wr_addr = 5'd0; wr_data = 32'h1234; rs_addr = 5'd8; rt_addr = 5'd0;
        #2 chk("wr8_next_cycle", rs_data, 32'hDEADBEEF);
        step(); reg_write = 1'b0;
        #2 chk("zero_reg", rt_data, 32'd0);

        // Fill then clear
        for (int i = 1; i < NREG; i++) begin
            step(); reg_write = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 3);
        end
        step(); reg_write = 1'b0; clear_req = 1'b1; rs_addr = 5'd10; rt_addr = 5'd20;
        #2 chk("reg20_pre", rt_data, 32'd60);
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            clear_req = (n == 5);
            #2;
            if (busy) busy_cnt++;
            if (n == 10) chk("reg10_before_slot", rs_data, 32'd30);
            if (n == 11) chk("reg10_after_slot", rs_data, 32'd0);
            if (n == 20) chk("reg20_before_slot", rt_data, 32'd60);
            if (n == 21) chk("reg20_after_slot", rt_data, 32'd0);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd31);
        sweep();
        step(); rs_addr = 5'd29; rt_addr = 5'd31;
        #2 chk("sp_after_clear", rs_data, 32'd227);
        chk("r31_after_clear", rt_data, 32'd0);

        // Write and clear request on the same edge
        step(); reg_write = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF; clear_req = 1'b1; rs_addr = 5'd31;
        step(); reg_write = 1'b0; clear_req = 1'b0;
        #2 chk("same_edge_commit", rs_data, 32'hFFFF);
        chk("same_edge_busy", 32'(busy), 32'd1);
        repeat (34) step();
        #2 chk("same_edge_cleared", rs_data, 32'd0);
        chk("same_edge_idle", 32'(busy), 32'd0);

        // Write held through a clear
        step(); reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
        step(); reg_write = 1'b0; clear_req = 1'b1; rs_addr = 5'd5;
        step(); clear_req = 1'b0; reg_write = 1'b1; wr_addr = 5'd5; wr_data = 32'hAA;
        ready_n = 0;
        for (int n = 2; n <= 40; n++) begin
            step();
            #2;
            if (n == 5) chk("reg5_before_slot", rs_data, 32'h55);
            if (n == 6) chk("reg5_after_slot", rs_data, 32'd0);
            if (wr_ready) begin
                ready_n = n;
                break;
            end
        end
        chk("blocked_release_cycle", 32'(ready_n), 32'd32);
        step(); reg_write = 1'b0;
        #2 chk("blocked_commit", rs_data, 32'hAA);

        // Reset in the middle of a clear
        step(); reg_write = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
        step(); wr_addr = 5'd25; wr_data = 32'h99;
        step(); reg_write = 1'b0; clear_req = 1'b1; rs_addr = 5'd20; rt_addr = 5'd29;
        step(); clear_req = 1'b0;
        repeat (11) step();
        #1 rst_n = 1'b0;
        #1 chk("midclr_busy", 32'(busy), 32'd0);
        chk("midclr_wr_ready", 32'(wr_ready), 32'd1);
        chk("midclr_reg20", rs_data, 32'd0);
        chk("midclr_sp", rt_data, 32'd227);
        rs_addr = 5'd25;
        #1 chk("midclr_reg25", rs_data, 32'd0);
        rst_n = 1'b1;
        sweep();
        step();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_bank_wb
